// File: rtl/pe1_wb_ctrl.sv
// PE1 write-back controller: tracks PE1 operand tags through a fixed-latency
// delay line, queues results in a 2-in/1-out FIFO and issues bank writes.
// Ports: start/mode (pass control), in_* (operand issue + credit),
// pe_out1/pe_out2 (PE1 results), wr_* (bank write), busy/done/err (status).
module pe1_wb_ctrl #(
  parameter int DW         = 24,
  parameter int AW         = 6,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [AW-1:0] in_addr0,
  input  logic [AW-1:0] in_addr1,
  output logic          in_ready,
  input  logic [DW-1:0] pe_out1,
  input  logic [DW-1:0] pe_out2,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 5;
  localparam int EW = AW + DW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic          vld;
    logic          last;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
  } tag_t;

  state_e        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  tag_t          dl_q [1:9];
  tag_t          dl_d [1:9];
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          last_q, last_d;
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic [3:0]    lat;
  logic          two;
  tag_t          tap;
  logic [1:0]    npush;
  logic          pop;
  logic          acc;
  logic          credit;
  logic [3:0]    nvld;
  logic [SW-1:0] infl;
  logic [EW-1:0] head;

  always_comb begin
    lat = 4'd9;
    unique case (mode_q)
      3'd0, 3'd1, 3'd4: lat = 4'd3;
      3'd5:             lat = 4'd4;
      default:          lat = 4'd9;
    endcase
  end

  assign two   = !(mode_q == 3'd0 || mode_q == 3'd2);
  assign tap   = dl_q[lat];
  assign npush = tap.vld ? (two ? 2'd2 : 2'd1) : 2'd0;

  assign wr_en = (cnt_q != '0);
  assign pop   = wr_en & wr_ready;
  assign head  = mem[rp_q];

  assign wr_addr = wr_en ? head[EW-1 -: AW] : '0;
  assign wr_data = wr_en ? head[DW-1:0] : '0;

  // Tags at or before the tap still owe FIFO entries.
  always_comb begin
    nvld = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (dl_q[i].vld && (4'(i) <= lat))
        nvld = nvld + 4'd1;
    end
  end

  assign infl   = two ? SW'({nvld, 1'b0})
                      : SW'(nvld);
  assign credit = (SW'(cnt_q) + infl + SW'(2))
                  <= SW'(FIFO_DEPTH);

  assign in_ready = (state_q == S_RUN) && credit;
  assign acc      = in_valid & in_ready;
  assign busy     = (state_q == S_RUN)
                 || (state_q == S_DRAIN);
  assign done     = done_q;
  assign err      = err_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q | (in_valid & ~acc);
    last_d  = last_q | (tap.vld & tap.last);
    cnt_d   = cnt_q + CW'(npush) - CW'(pop);
    wp_d    = wp_q + PW'(npush);
    rp_d    = rp_q + PW'(pop);

    dl_d[1]      = '0;
    dl_d[1].vld  = acc;
    dl_d[1].last = acc & in_last;
    dl_d[1].a0   = acc ? in_addr0 : '0;
    dl_d[1].a1   = acc ? in_addr1 : '0;
    // Stages past the tap are flushed so a later
    // longer-latency pass never sees stale tags.
    for (int i = 2; i <= 9; i++) begin
      dl_d[i] = (4'(i) <= lat) ? dl_q[i-1] : '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode < 3'd6) begin
            state_d = S_RUN;
            mode_d  = mode;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (acc && in_last)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_d && (cnt_d == '0))
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 3'd0;
      rp_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 1; i <= 9; i++)
        dl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      last_q  <= last_d;
      for (int i = 1; i <= 9; i++)
        dl_q[i] <= dl_d[i];
    end
  end

  // Two-entry write port: out1 entry first,
  // out2 entry in the following slot.
  always_ff @(posedge clk) begin
    if (npush != 2'd0)
      mem[wp_q] <= {tap.a0, pe_out1};
    if (npush == 2'd2)
      mem[wp_q + PW'(1)] <= {tap.a1, pe_out2};
  end

endmodule

// File: tb/tb_pe1_wb_ctrl.sv
// Testbench for pe1_wb_ctrl: queue-based reference model checked
// every cycle plus directed scenarios with literal expectations.
module tb_pe1_wb_ctrl;
  localparam int DW = 24;
  localparam int AW = 6;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [AW-1:0] in_addr0 = '0;
  logic [AW-1:0] in_addr1 = '0;
  logic          in_ready;
  logic [DW-1:0] pe_out1;
  logic [DW-1:0] pe_out2;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tog = 0;
  logic          ovr = 1'b0;
  logic [DW-1:0] ovr1 = '0;
  logic [DW-1:0] ovr2 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(int c, int k);
    return DW'(c * 32'h00010307 + k * 32'h000A0B0C
               + 32'h003C3C3C);
  endfunction

  assign pe_out1 = ovr ? ovr1 : pat(cyc, 0);
  assign pe_out2 = ovr ? ovr2 : pat(cyc, 1);

  pe1_wb_ctrl #(.DW(DW), .AW(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_last(in_last),
    .in_addr0(in_addr0), .in_addr1(in_addr1),
    .in_ready(in_ready), .pe_out1(pe_out1),
    .pe_out2(pe_out2), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy),
    .done(done), .err(err)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(logic [2:0] m);
    case (m)
      3'd0, 3'd1, 3'd4: return 3;
      3'd5:             return 4;
      default:          return 9;
    endcase
  endfunction

  function automatic bit two_of(logic [2:0] m);
    return !(m == 3'd0 || m == 3'd2);
  endfunction

  // Reference model: pass phase, pending results, write queue.
  int            ph = 0;
  bit            m_err = 0;
  logic [2:0]    m_mode = 3'd0;
  logic [AW-1:0] q_a [$];
  logic [DW-1:0] q_d [$];
  int            s_c [$];
  logic [AW-1:0] s_a [$];
  bit            s_p [$];
  logic [AW-1:0] wlog [$];
  logic [AW-1:0] ex_log [$];
  int            ndone = 0;
  bit            prev_en = 0;
  bit            prev_rdy = 0;
  logic [AW-1:0] prev_a = '0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clk) begin : cmp
    logic [34:0]   act_v;
    logic [34:0]   exp_v;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            er;
    bit            qne;
    int            ph_n;
    act_v = {in_ready, busy, done, err,
             wr_en, wr_addr, wr_data};
    if (!rst) begin
      q_a.delete(); q_d.delete();
      s_c.delete(); s_a.delete(); s_p.delete();
      ph = 0; m_err = 0; prev_en = 0;
      chk("reset_outs", 64'(act_v), 64'd0);
    end else begin
      qne = (q_a.size() > 0);
      er  = (ph == 1)
         && (q_a.size() + s_c.size() + 2 <= D);
      ea  = qne ? q_a[0] : '0;
      ed  = qne ? q_d[0] : '0;
      exp_v = {er, (ph == 1 || ph == 2), (ph == 3),
               m_err, qne, ea, ed};
      chk("outputs", 64'(act_v), 64'(exp_v));
      if (prev_en && !prev_rdy)
        chk("stall_hold", {wr_en, wr_addr, wr_data},
            {1'b1, prev_a, prev_d});
      prev_en  = wr_en;
      prev_rdy = wr_ready;
      prev_a   = wr_addr;
      prev_d   = wr_data;
      if (wr_en && wr_ready) wlog.push_back(wr_addr);
      if (done) ndone++;

      if (qne && wr_ready) begin
        void'(q_a.pop_front());
        void'(q_d.pop_front());
      end
      while (s_c.size() > 0 && s_c[0] == cyc) begin
        q_a.push_back(s_a[0]);
        q_d.push_back(s_p[0] ? pe_out2 : pe_out1);
        void'(s_c.pop_front());
        void'(s_a.pop_front());
        void'(s_p.pop_front());
      end
      ph_n = ph;
      if (in_valid) begin
        if (er) begin
          s_c.push_back(cyc + lat_of(m_mode));
          s_a.push_back(in_addr0);
          s_p.push_back(1'b0);
          if (two_of(m_mode)) begin
            s_c.push_back(cyc + lat_of(m_mode));
            s_a.push_back(in_addr1);
            s_p.push_back(1'b1);
          end
          if (in_last) ph_n = 2;
        end else begin
          m_err = 1;
        end
      end
      case (ph)
        0: if (start) begin
          if (mode < 3'd6) begin
            ph_n = 1; m_mode = mode;
          end else m_err = 1;
        end
        2: if (s_c.size() == 0 && q_a.size() == 0)
          ph_n = 3;
        3: ph_n = 0;
        default: ;
      endcase
      ph = ph_n;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (tog) wr_ready = ~wr_ready;
  endtask

  task automatic do_start(input logic [2:0] m);
    start = 1'b1; mode = m;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1,
                       input logic last);
    in_valid = 1'b1; in_addr0 = a0;
    in_addr1 = a1; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick(); n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    tick();
  endtask

  task automatic chk_log();
    chk("wr_count", 64'(wlog.size()), 64'(ex_log.size()));
    for (int i = 0; i < ex_log.size(); i++)
      if (i < wlog.size())
        chk("wr_order", 64'(wlog[i]), 64'(ex_log[i]));
    wlog.delete();
    ex_log.delete();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    int n;
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {in_ready, busy, done, err, wr_en}, 0);
    rst = 1'b1;
    tick();

    // Single K4NTT set with literal results.
    do_start(3'd1);
    t = cyc;
    issue(6'd5, 6'd37, 1'b1);
    tick(); tick();
    ovr1 = 24'h123456; ovr2 = 24'h0ABCDE; ovr = 1'b1;
    tick();
    ovr = 1'b0;
    chk("k4ntt_t4", {cyc - t, wr_en, wr_addr, wr_data},
        {32'd4, 1'b1, 6'd5, 24'h123456});
    tick();
    chk("k4ntt_t5", {wr_en, wr_addr, wr_data},
        {1'b1, 6'd37, 24'h0ABCDE});
    tick();
    chk("k4ntt_done", {done, busy}, 2'b10);
    tick();
    chk("k4ntt_idle", {done, busy, wr_en}, 3'b000);
    wlog.delete();

    // K2INTT back-to-back, only out1 written.
    do_start(3'd2);
    t = cyc;
    for (int i = 0; i < 4; i++)
      issue(6'(i), 6'(40 + i), 1'(i == 3));
    repeat (5) tick();
    chk("k2intt_pre", {cyc - t, wr_en}, {32'd9, 1'b0});
    tick();
    chk("k2intt_first", {wr_en, wr_addr}, {1'b1, 6'd0});
    wait_done(50);
    for (int i = 0; i < 4; i++) ex_log.push_back(6'(i));
    chk_log();

    // K4INTT with bank stalled, FIFO fills to 16.
    wr_ready = 1'b0;
    ndone = 0;
    do_start(3'd3);
    for (int i = 0; i < 8; i++)
      issue(6'(2 * i), 6'(2 * i + 1), 1'(i == 7));
    repeat (12) tick();
    chk("k4intt_full", {in_ready, wr_en, busy, wr_addr},
        {1'b0, 1'b1, 1'b1, 6'd0});
    wr_ready = 1'b1;
    wait_done(60);
    chk("k4intt_one_done", 64'(ndone), 64'd1);
    for (int i = 0; i < 16; i++) ex_log.push_back(6'(i));
    chk_log();

    // Credit: K4NTT stalled, issue whenever ready.
    wr_ready = 1'b0;
    do_start(3'd1);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin
        issue(6'(2 * k), 6'(2 * k + 1), 1'b0);
        k++;
      end else tick();
    end
    chk("credit_sets", 64'(k), 64'd8);
    chk("credit_block", {in_ready, busy}, 2'b01);
    wr_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      tick(); n++;
    end
    chk("credit_reopen", 64'(in_ready), 64'd1);
    issue(6'd50, 6'd51, 1'b1);
    wait_done(60);
    for (int i = 0; i < 16; i++) ex_log.push_back(6'(i));
    ex_log.push_back(6'd50);
    ex_log.push_back(6'd51);
    chk_log();

    // Illegal mode.
    do_start(3'd6);
    chk("illegal_mode", {err, busy}, 2'b10);
    issue(6'd9, 6'd10, 1'b1);
    repeat (15) tick();
    chk("illegal_nowrite", {64'(wlog.size()), busy}, 0);

    // Reset mid-pass with 3 entries queued (DINTT).
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("err_cleared", 64'(err), 64'd0);
    wr_ready = 1'b0;
    do_start(3'd5);
    issue(6'd1, 6'd2, 1'b0);
    issue(6'd3, 6'd4, 1'b0);
    repeat (4) tick();
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("dintt_three", {wr_en, wr_addr}, {1'b1, 6'd2});
    rst = 1'b0;
    #1;
    chk("async_rst", {wr_en, wr_addr, wr_data, busy, err}, 0);
    tick();
    rst = 1'b1;
    wr_ready = 1'b1;
    wlog.delete();
    repeat (20) tick();
    chk("post_rst", {64'(wlog.size()), busy, err, wr_en}, 0);

    // DNTT with toggling bank ready and a mid-pass start.
    do_start(3'd4);
    tog = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        start = 1'b1; mode = 3'd2;
      end
      issue(6'(10 + i), 6'(30 + i), 1'(i == 5));
      start = 1'b0;
    end
    wait_done(80);
    tog = 0;
    wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ex_log.push_back(6'(10 + i));
      ex_log.push_back(6'(30 + i));
    end
    chk_log();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pe1_wb_ctrl.md
PE1_WB_CTRL -- requirements
Module: pe1_wb_ctrl

Interface
REQ-001 Parameter DW, default 24, data word width (two packed 12-bit coefficients).
REQ-002 Parameter AW, default 6, bank address width.
REQ-003 Parameter FIFO_DEPTH, default 16, write-back FIFO entries (power of two).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a pass; sampled only in IDLE.
REQ-007 mode  input  3  pass mode, latched on start: 0 K2NTT, 1 K4NTT, 2 K2INTT, 3 K4INTT, 4 DNTT, 5 DINTT; 6/7 illegal.
REQ-008 in_valid  input  1  an operand set was issued to PE1 this cycle.
REQ-009 in_last  input  1  qualifies in_valid; marks final operand set of the pass.
REQ-010 in_addr0/in_addr1  input  AW each  destination addresses for PE1_out1/PE1_out2 of this operand set.
REQ-011 in_ready  output  1  controller may issue an operand set this cycle.
REQ-012 pe_out1/pe_out2  input  DW each  PE1 result ports.
REQ-013 wr_en, wr_addr[AW], wr_data[DW]  output  bank write request.
REQ-014 wr_ready  input  1  bank accepts the write when wr_en and wr_ready are both high.
REQ-015 busy  output  1  high in RUN or DRAIN.
REQ-016 done  output  1  one-cycle pulse at pass completion.
REQ-017 err  output  1  sticky; set on illegal mode or in_valid outside RUN.

Function
REQ-018 States: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with legal mode; start with illegal mode sets err and stays IDLE.
REQ-019 RUN->DRAIN on the cycle in_valid&in_last is accepted; DRAIN->DONE when delay line and FIFO are both empty; DONE->IDLE after exactly one cycle with done=1.
REQ-020 PE1 latency L(mode), in cycles from in_valid to result on pe_out*, is fixed: K2NTT 3, K4NTT 3, DNTT 3, DINTT 4, K2INTT 9, K4INTT 9.
REQ-021 Tags (valid, addr0, addr1, last) travel through a 9-stage shift register; the tag is taken from tap L(mode); pe_out1/pe_out2 are sampled in the same cycle the tag emerges.
REQ-022 K2NTT and K2INTT: only pe_out1 is valid; one FIFO entry (in_addr0, pe_out1) is pushed per tag.
REQ-023 All other modes: two entries are pushed in the same cycle, (addr0, pe_out1) then (addr1, pe_out2); the FIFO has a two-entry write port.
REQ-024 Writes issue in FIFO order; wr_en=1 whenever FIFO is non-empty; wr_addr/wr_data present the head entry; pop on wr_en&wr_ready.
REQ-025 wr_addr/wr_data stay stable while wr_en=1 and wr_ready=0.
REQ-026 Credit rule: in_ready = (state==RUN) and (fifo_count + inflight_entries + 2 <= FIFO_DEPTH), where inflight_entries = entries per tag (1 or 2) times the number of valid tags in the delay line.
REQ-027 Because of REQ-026 the FIFO never overflows; an in_valid with in_ready=0 is ignored and sets err.
REQ-028 Push and pop in the same cycle: count updates by pushes minus pop; pointers wrap modulo FIFO_DEPTH.
REQ-029 in_valid outside RUN is ignored (no tag enters) and sets err.
REQ-030 start while not in IDLE is ignored; mode is not re-latched mid-pass.

Reset
REQ-031 rst low, asynchronously: state=IDLE; delay line, FIFO pointers and count cleared; wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=0, done=0, err=0.
REQ-032 Reset mid-pass discards all in-flight tags and queued writes; no write issues after rst deasserts until a new pass supplies data.

Verification
REQ-033 K4NTT, wr_ready=1, one in_valid (addr0=5, addr1=37, last) at cycle t, pe_out1=0x123456, pe_out2=0x0ABCDE at t+3 -> wr (5,0x123456) at t+4, wr (37,0x0ABCDE) at t+5, done at t+6.
REQ-034 K2INTT, 4 back-to-back sets, addr0=0..3 -> exactly 4 writes to 0..3 in order, first at issue+10, pe_out2 never written.
REQ-035 K4INTT, wr_ready=0 held, continuous in_valid -> in_ready falls so fifo_count+inflight never exceeds 16; after wr_ready=1, all 16 writes drain in order, done pulses once.
REQ-036 start with mode=6 -> err=1, state stays IDLE, busy=0; subsequent in_valid produces no write.
REQ-037 DINTT pass, rst pulled low while FIFO holds 3 entries -> wr_en=0 immediately; after release, no writes, busy=0, err=0.
REQ-038 DNTT with wr_ready toggling 1/0 each cycle -> wr_addr/wr_data stable during stalls, sequence matches issue order with no loss or duplication.
